// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Multi-cycle sequencer for the MIPS datapath. It walks each instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives the datapath strobes for the
// current state. Bus transfers stall on waitrequest. The sequencer halts when the
// fetch PC is zero. A sticky bus_error is raised if a transfer stalls too long.
//
// Parameters
//   RESET_IDLE_CYCLES  IDLE cycles after reset release before the first FETCH (>=1)
//   WAIT_LIMIT         max consecutive stalled cycles per transfer, 0 = unlimited
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   instr              latched IR (meaningful from DECODE onward)
//   pc_is_zero         PC == 0, checked when FETCH is entered
//   alu_zero           ALU zero flag for BEQ/BNE in EXEC
//   waitrequest        bus stall for the current read/write request
//   active             1 in every state except IDLE and HALT
//   mem_read/mem_write bus requests (never both)
//   addr_sel           bus address from PC (0) or ALU result (1)
//   ir_write, pc_write, pc_write_br, reg_write   single-cycle strobes
//   reg_dst            write register select: 0 rt, 1 rd, 2 r31
//   mem_to_reg         writeback takes load data
//   alu_src_imm        ALU B operand from the extended immediate
//   bus_error          sticky wait-limit overrun flag
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int RESET_IDLE_CYCLES = 1,
    parameter int WAIT_LIMIT        = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        pc_is_zero,
    input  logic        alu_zero,
    input  logic        waitrequest,
    output logic        active,
    output logic        mem_read,
    output logic        mem_write,
    output logic        addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_write_br,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_imm,
    output logic        bus_error
);

    localparam int IDLE_W = (RESET_IDLE_CYCLES < 2) ? 1 : $clog2(RESET_IDLE_CYCLES);
    localparam int WAIT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

    typedef enum logic [2:0] {
        sIdle, sFetch, sDecode, sExec, sMem, sWb, sHalt
    } ctrlState_t;

    ctrlState_t        state, nextState;
    logic [IDLE_W-1:0] idleCnt;
    logic [WAIT_W-1:0] waitCnt;
    logic              stalled;     // last cycle was a stalled bus request
    logic              busStall;
    logic              timeout;
    logic              fetchSkip;
    logic              isLoad;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic              unusedInstrBits;

    assign opcode          = instr[31:26];
    assign funct           = instr[5:0];
    assign isLoad          = (opcode[5:3] == 3'b100);
    assign unusedInstrBits = ^instr[25:6];

    assign busStall = (mem_read | mem_write) & waitrequest;

    // The PC-zero check applies only on the first FETCH cycle, so a transfer
    // already in flight is never abandoned.
    assign fetchSkip = (state == sFetch) && !stalled && pc_is_zero;

    always_comb begin
        timeout = 1'b0;
        if (WAIT_LIMIT > 0 && busStall)
            timeout = (int'(waitCnt) + 1 >= WAIT_LIMIT);
    end

    // State register and bookkeeping counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= sIdle;
            idleCnt   <= '0;
            waitCnt   <= '0;
            stalled   <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            state   <= nextState;
            stalled <= busStall && !timeout;
            if (state == sIdle)
                idleCnt <= idleCnt + 1'b1;
            else
                idleCnt <= '0;
            // Counter restarts whenever the bus is not stalling (completion or no request).
            if (WAIT_LIMIT > 0 && busStall && !timeout)
                waitCnt <= waitCnt + 1'b1;
            else
                waitCnt <= '0;
            if (timeout)
                bus_error <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            sIdle:   if (int'(idleCnt) >= RESET_IDLE_CYCLES - 1) nextState = sFetch;
            sFetch: begin
                if (fetchSkip || timeout) nextState = sHalt;
                else if (!waitrequest)    nextState = sDecode;
            end
            sDecode: nextState = sExec;
            sExec: begin
                casez (opcode)
                    6'b000000: nextState = (funct == 6'b001000 || funct == 6'b001001) ? sFetch : sWb;
                    6'b001???: nextState = sWb;
                    6'b10????: nextState = sMem;
                    default:   nextState = sFetch;
                endcase
            end
            sMem: begin
                if (timeout)           nextState = sHalt;
                else if (!waitrequest) nextState = isLoad ? sWb : sFetch;
            end
            sWb:     nextState = sFetch;
            sHalt:   nextState = sHalt;
            default: nextState = sIdle;
        endcase
    end

    // Output logic
    always_comb begin
        active      = (state != sIdle) && (state != sHalt);
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        addr_sel    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_write_br = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 2'd0;
        mem_to_reg  = 1'b0;
        alu_src_imm = 1'b0;
        case (state)
            sFetch: begin
                if (!fetchSkip) begin
                    mem_read = 1'b1;
                    ir_write = !waitrequest;
                    pc_write = !waitrequest;
                end
            end
            sExec: begin
                casez (opcode)
                    6'b000000: begin
                        if (funct == 6'b001000) begin
                            pc_write = 1'b1;
                        end else if (funct == 6'b001001) begin
                            pc_write  = 1'b1;
                            reg_write = 1'b1;
                            reg_dst   = 2'd1;
                        end
                    end
                    6'b001???: alu_src_imm = 1'b1;
                    6'b10????: alu_src_imm = 1'b1;
                    6'b000100: pc_write_br = alu_zero;
                    6'b000101: pc_write_br = !alu_zero;
                    6'b000010: pc_write = 1'b1;
                    6'b000011: begin
                        pc_write  = 1'b1;
                        reg_write = 1'b1;
                        reg_dst   = 2'd2;
                    end
                    default: ;
                endcase
            end
            sMem: begin
                addr_sel    = 1'b1;
                alu_src_imm = 1'b1;
                mem_read    = isLoad;
                mem_write   = !isLoad;
            end
            sWb: begin
                reg_write   = 1'b1;
                reg_dst     = (opcode == 6'b000000) ? 2'd1 : 2'd0;
                mem_to_reg  = isLoad;
                alu_src_imm = (opcode[5:3] == 3'b001);
            end
            default: ;
        endcase
    end

endmodule
